hazard_controller: RTL and testbench

- Central pipeline sequencing block for the 5-stage in-order core.
- Decides per-cycle stall, bubble and flush controls for IF/ID/EX/MEM/WB pipeline registers.
- Covers load-use hazards (not resolvable by EX/MEM/WB forwarding), multi-cycle mul/div occupancy, data-memory wait states and taken-branch redirects.
- Sits beside the operand forwarding logic; the forwarding logic handles only single-cycle ALU-to-ALU dependencies.

---
 rtl/cpu_pipeline_pkg.sv | 35 +++
 rtl/load_use_detect.sv | 24 ++
 rtl/hazard_controller.sv | 133 +++++++++++++
 tb/tb_hazard_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipeline_pkg.sv
// Shared types for the pipeline sequencing logic: hazard FSM states and the
// bundled stall/bubble/flush control word.
package cpu_pipeline_pkg;

  localparam int REG_ID_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    RUN,
    MD_WAIT,
    MEM_WAIT
  } hazard_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic bubble_ex;
    logic bubble_mem;
    logic bubble_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } pipe_ctrl_t;

  // Canonical control patterns; every cycle drives exactly one of these.
  localparam pipe_ctrl_t CTRL_NONE = '0;
  localparam pipe_ctrl_t CTRL_MEM_HOLD = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1,
                                           stall_mem: 1'b1, bubble_wb: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_MD_HOLD = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1,
                                          bubble_mem: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{flush_if_id: 1'b1, flush_id_ex: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{stall_if: 1'b1, stall_id: 1'b1, bubble_ex: 1'b1,
                                           default: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX;
// register 0 is hard-wired and never creates a dependency.
module load_use_detect
  import cpu_pipeline_pkg::*;
#(
  parameter int REG_ID_WIDTH = REG_ID_WIDTH_DEF
) (
  input  logic [REG_ID_WIDTH-1:0] id_rs1,
  input  logic [REG_ID_WIDTH-1:0] id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic                    id_ex_mem_read,
  input  logic [REG_ID_WIDTH-1:0] id_ex_dest,
  output logic                    lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == id_ex_dest);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == id_ex_dest);
  assign lu      = id_ex_mem_read && (id_ex_dest != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_controller.sv
// Per-cycle stall/bubble/flush sequencing for the 5-stage core: load-use,
// multi-cycle mul/div, data-memory wait states and taken-branch redirects.
module hazard_controller
  import cpu_pipeline_pkg::*;
#(
  parameter int REG_ID_WIDTH    = REG_ID_WIDTH_DEF,
  parameter int STALL_CNT_WIDTH = 32,
  parameter int MD_TIMEOUT      = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REG_ID_WIDTH-1:0]    id_rs1,
  input  logic [REG_ID_WIDTH-1:0]    id_rs2,
  input  logic                       id_uses_rs1,
  input  logic                       id_uses_rs2,
  input  logic                       id_ex_mem_read,
  input  logic [REG_ID_WIDTH-1:0]    id_ex_dest,
  input  logic                       ex_branch_taken,
  input  logic                       ex_muldiv_start,
  input  logic                       muldiv_done,
  input  logic                       mem_req_valid,
  input  logic                       mem_ready,
  output logic                       stall_if,
  output logic                       stall_id,
  output logic                       stall_ex,
  output logic                       stall_mem,
  output logic                       bubble_ex,
  output logic                       bubble_mem,
  output logic                       bubble_wb,
  output logic                       flush_if_id,
  output logic                       flush_id_ex,
  output logic [STALL_CNT_WIDTH-1:0] stall_count,
  output logic                       md_timeout_err
);

  localparam int TMO_W = $clog2(MD_TIMEOUT + 1);

  hazard_state_e        state_q, state_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic [STALL_CNT_WIDTH-1:0] cnt_q, cnt_d;
  pipe_ctrl_t           ctrl;
  logic                 lu;

  load_use_detect #(
    .REG_ID_WIDTH(REG_ID_WIDTH)
  ) u_load_use_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_dest    (id_ex_dest),
    .lu            (lu)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (mem_req_valid && !mem_ready) begin
          state_d = MEM_WAIT;
        end else if (ex_muldiv_start && !muldiv_done) begin
          state_d = MD_WAIT;
          tmo_d   = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) state_d = RUN;
      end
      MD_WAIT: begin
        if (muldiv_done) begin
          state_d = RUN;
        end else begin
          // Counter parks at MD_TIMEOUT so a hung unit never wraps it back.
          if (tmo_q != TMO_W'(MD_TIMEOUT)) tmo_d = tmo_q + 1'b1;
          if (tmo_q >= TMO_W'(MD_TIMEOUT - 1)) err_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctrl = CTRL_NONE;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (mem_req_valid && !mem_ready)            ctrl = CTRL_MEM_HOLD;
          else if (ex_muldiv_start && !muldiv_done)   ctrl = CTRL_MD_HOLD;
          else if (ex_branch_taken)                   ctrl = CTRL_REDIRECT;
          else if (lu)                                ctrl = CTRL_LOAD_USE;
        end
        MEM_WAIT: if (!mem_ready)   ctrl = CTRL_MEM_HOLD;
        MD_WAIT:  if (!muldiv_done) ctrl = CTRL_MD_HOLD;
        default:  ctrl = CTRL_NONE;
      endcase
    end
  end

  assign cnt_d = (ctrl.stall_if && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  assign stall_if       = ctrl.stall_if;
  assign stall_id       = ctrl.stall_id;
  assign stall_ex       = ctrl.stall_ex;
  assign stall_mem      = ctrl.stall_mem;
  assign bubble_ex      = ctrl.bubble_ex;
  assign bubble_mem     = ctrl.bubble_mem;
  assign bubble_wb      = ctrl.bubble_wb;
  assign flush_if_id    = ctrl.flush_if_id;
  assign flush_id_ex    = ctrl.flush_id_ex;
  assign stall_count    = cnt_q;
  assign md_timeout_err = err_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Two hazard_controller instances (wide/slow-timeout and narrow/fast-timeout)
// share stimulus and are compared every cycle against a rule-level model.
module tb_hazard_controller;

  localparam int RW   = 5;
  localparam int CW_A = 8;
  localparam int TO_A = 16;
  localparam int CW_B = 3;
  localparam int TO_B = 4;

  // Control vector order: stall_if, stall_id, stall_ex, stall_mem,
  // bubble_ex, bubble_mem, bubble_wb, flush_if_id, flush_id_ex.
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_MEM  = 9'b111100100;
  localparam logic [8:0] C_MD   = 9'b111001000;
  localparam logic [8:0] C_BR   = 9'b000000011;
  localparam logic [8:0] C_LU   = 9'b110010000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_ex_dest = '0;
  logic          id_uses_rs1 = 0, id_uses_rs2 = 0, id_ex_mem_read = 0;
  logic          ex_branch_taken = 0, ex_muldiv_start = 0, muldiv_done = 0;
  logic          mem_req_valid = 0, mem_ready = 0;

  wire [8:0]      ctrl_a, ctrl_b;
  wire [CW_A-1:0] cnt_a;
  wire [CW_B-1:0] cnt_b;
  wire            err_a, err_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_controller #(.REG_ID_WIDTH(RW), .STALL_CNT_WIDTH(CW_A), .MD_TIMEOUT(TO_A)) u_dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_dest(id_ex_dest),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
    .muldiv_done(muldiv_done), .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
    .stall_if(ctrl_a[8]), .stall_id(ctrl_a[7]), .stall_ex(ctrl_a[6]), .stall_mem(ctrl_a[5]),
    .bubble_ex(ctrl_a[4]), .bubble_mem(ctrl_a[3]), .bubble_wb(ctrl_a[2]),
    .flush_if_id(ctrl_a[1]), .flush_id_ex(ctrl_a[0]),
    .stall_count(cnt_a), .md_timeout_err(err_a)
  );

  hazard_controller #(.REG_ID_WIDTH(RW), .STALL_CNT_WIDTH(CW_B), .MD_TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_dest(id_ex_dest),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
    .muldiv_done(muldiv_done), .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
    .stall_if(ctrl_b[8]), .stall_id(ctrl_b[7]), .stall_ex(ctrl_b[6]), .stall_mem(ctrl_b[5]),
    .bubble_ex(ctrl_b[4]), .bubble_mem(ctrl_b[3]), .bubble_wb(ctrl_b[2]),
    .flush_if_id(ctrl_b[1]), .flush_id_ex(ctrl_b[0]),
    .stall_count(cnt_b), .md_timeout_err(err_b)
  );

  // ---------------- behavioural model ----------------
  bit     m_mem_wait = 0;   // a data-memory request is outstanding
  bit     m_md_wait  = 0;   // a mul/div op is outstanding
  int     m_wait     = 0;   // cycles spent waiting on mul/div without done
  longint m_cnt[2]   = '{0, 0};
  bit     m_err[2]   = '{0, 0};

  function automatic longint cap(input int i);
    return (i == 0) ? longint'((1 << CW_A) - 1) : longint'((1 << CW_B) - 1);
  endfunction

  function automatic int tmo(input int i);
    return (i == 0) ? TO_A : TO_B;
  endfunction

  function automatic logic [8:0] exp_ctrl();
    bit lu;
    lu = id_ex_mem_read && (id_ex_dest != 0) &&
         ((id_uses_rs1 && id_rs1 == id_ex_dest) || (id_uses_rs2 && id_rs2 == id_ex_dest));
    if (reset)                                   return C_NONE;
    if (m_mem_wait)                              return mem_ready ? C_NONE : C_MEM;
    if (m_md_wait)                               return muldiv_done ? C_NONE : C_MD;
    if (mem_req_valid && !mem_ready)             return C_MEM;
    if (ex_muldiv_start && !muldiv_done)         return C_MD;
    if (ex_branch_taken)                         return C_BR;
    if (lu)                                      return C_LU;
    return C_NONE;
  endfunction

  always @(posedge clk) begin : model_update
    logic [8:0] e;
    e = exp_ctrl();
    if (reset) begin
      m_mem_wait <= 0;
      m_md_wait  <= 0;
      m_wait     <= 0;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] <= 0;
        m_err[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        if (e[8] && m_cnt[i] < cap(i)) m_cnt[i] <= m_cnt[i] + 1;
      if (m_mem_wait) begin
        if (mem_ready) m_mem_wait <= 0;
      end else if (m_md_wait) begin
        if (muldiv_done) m_md_wait <= 0;
        else begin
          m_wait <= m_wait + 1;
          for (int i = 0; i < 2; i++)
            if (m_wait + 1 >= tmo(i)) m_err[i] <= 1;
        end
      end else if (mem_req_valid && !mem_ready) begin
        m_mem_wait <= 1;
      end else if (ex_muldiv_start && !muldiv_done) begin
        m_md_wait <= 1;
        m_wait    <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [8:0] e;
    e = exp_ctrl();
    check("ctrl_a", 64'(ctrl_a), 64'(e));
    check("ctrl_b", 64'(ctrl_b), 64'(e));
    check("cnt_a", 64'(cnt_a), 64'(m_cnt[0]));
    check("cnt_b", 64'(cnt_b), 64'(m_cnt[1]));
    check("err_a", 64'(err_a), 64'(m_err[0]));
    check("err_b", 64'(err_b), 64'(m_err[1]));
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    reset = 0; id_rs1 = '0; id_rs2 = '0; id_ex_dest = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_ex_mem_read = 0;
    ex_branch_taken = 0; ex_muldiv_start = 0; muldiv_done = 0;
    mem_req_valid = 0; mem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic set_lu();
    id_ex_mem_read = 1; id_ex_dest = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
  endtask

  initial begin
    // Reset with a memory miss pending: outputs must stay quiet.
    idle(); reset = 1; mem_req_valid = 1;
    smp();
    check("rst_ctrl", 64'(ctrl_a), 64'(C_NONE));
    cyc(); smp();
    check("rst_cnt", 64'(cnt_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);

    // Load-use: one cycle of stall + bubble.
    cyc(); set_lu(); smp();
    check("lu_ctrl", 64'(ctrl_a), 64'(C_LU));
    cyc(); smp();
    check("lu_release", 64'(ctrl_a), 64'(C_NONE));
    check("lu_cnt", 64'(cnt_a), 64'd1);

    // Destination x0 never hazards.
    cyc(); id_ex_mem_read = 1; id_uses_rs1 = 1; smp();
    check("lu_x0", 64'(ctrl_a), 64'(C_NONE));

    // Branch wins over load-use.
    cyc(); set_lu(); ex_branch_taken = 1; smp();
    check("br_lu_ctrl", 64'(ctrl_a), 64'(C_BR));
    cyc(); smp();
    check("br_lu_cnt", 64'(cnt_a), 64'd1);

    // Memory miss for 3 cycles; branch during the wait is ignored.
    for (int k = 0; k < 3; k++) begin
      cyc(); mem_req_valid = 1;
      if (k == 1) begin set_lu(); ex_branch_taken = 1; end
      smp();
      check("miss_ctrl", 64'(ctrl_a), 64'(C_MEM));
    end
    cyc(); mem_req_valid = 1; mem_ready = 1; smp();
    check("miss_release", 64'(ctrl_a), 64'(C_NONE));
    cyc(); smp();
    check("miss_cnt", 64'(cnt_a), 64'd4);

    // Mul/div completing 10 cycles after launch.
    cyc(); ex_muldiv_start = 1; smp();
    check("md_launch", 64'(ctrl_a), 64'(C_MD));
    for (int k = 1; k < 10; k++) begin
      cyc();
      if (k == 5) mem_req_valid = 1;
      smp();
      check("md_hold", 64'(ctrl_a), 64'(C_MD));
    end
    cyc(); muldiv_done = 1; smp();
    check("md_release", 64'(ctrl_a), 64'(C_NONE));
    cyc(); smp();
    check("md_cnt_a", 64'(cnt_a), 64'd14);
    check("md_err_a", 64'(err_a), 64'd0);
    check("md_sat_b", 64'(cnt_b), 64'd7);
    check("md_err_b", 64'(err_b), 64'd1);

    // Timeout on the fast instance, then reset with a done pending.
    cyc(); reset = 1; smp();
    check("to_rst_ctrl", 64'(ctrl_b), 64'(C_NONE));
    cyc(); smp();
    check("to_rst_err", 64'(err_b), 64'd0);
    check("to_rst_cnt", 64'(cnt_b), 64'd0);
    cyc(); ex_muldiv_start = 1; smp();
    for (int k = 1; k <= 4; k++) begin cyc(); smp(); end
    check("to_before", 64'(err_b), 64'd0);
    cyc(); smp();
    check("to_set", 64'(err_b), 64'd1);
    check("to_state", 64'(ctrl_b), 64'(C_MD));
    for (int k = 0; k < 4; k++) begin cyc(); smp(); end
    check("to_sticky", 64'(err_b), 64'd1);
    check("to_sat", 64'(cnt_b), 64'd7);
    cyc(); reset = 1; muldiv_done = 1; smp();
    check("to_rst_out", 64'(ctrl_b), 64'(C_NONE));
    cyc(); muldiv_done = 1; smp();
    check("to_clr_err", 64'(err_b), 64'd0);
    check("to_clr_ctrl", 64'(ctrl_b), 64'(C_NONE));

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset           = ($urandom_range(0, 149) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_ex_dest      = 5'($urandom_range(0, 3));
      id_uses_rs1     = ($urandom_range(0, 1) == 0);
      id_uses_rs2     = ($urandom_range(0, 1) == 0);
      id_ex_mem_read  = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      ex_muldiv_start = ($urandom_range(0, 5) == 0);
      muldiv_done     = ($urandom_range(0, 5) == 0);
      mem_req_valid   = ($urandom_range(0, 3) == 0);
      mem_ready       = ($urandom_range(0, 2) == 0);
    end

    cyc(); smp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
